mult_share_arbiter: RTL and testbench

- Shares one start-pulsed sequential 8x8 multiplier (multiplier_8Bit class: start pulse, input_0/input_1, 16-bit out) between NUM_REQ requesters, e.g. FFT butterfly twiddle lanes.
- Round-robin arbitration with one operation in flight at a time.
- Latches the winner's operands, pulses the multiplier start, and waits a fixed latency.
- Returns the 16-bit product with a one-cycle valid strobe to the owning requester.

---
 rtl/mult_share_arbiter.sv | 145 ++++++++++++++
 tb/tb_mult_share_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin front end that shares one start-pulsed sequential 8x8 multiplier
// between NUM_REQ requesters. Only one operation is in flight at a time. The
// product goes back to the requester that owns it with a one-cycle strobe.

// Per-lane decode: turns the shared winner/owner index into this lane's strobes.
module mult_share_lane #(
  parameter int LANE  = 0,
  parameter int IDX_W = 2
) (
  input  logic             grant_en,
  input  logic [IDX_W-1:0] winner,
  input  logic             done,
  input  logic [IDX_W-1:0] owner,
  output logic             gnt,
  output logic             res_valid
);
  assign gnt       = grant_en && (winner == IDX_W'(LANE));
  assign res_valid = done && (owner == IDX_W'(LANE));
endmodule

module mult_share_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 9,
  parameter int CNT_W        = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   res_valid,
  output logic [15:0]          res_data,
  output logic                 busy,
  output logic                 mult_start,
  output logic [7:0]           mult_in0,
  output logic [7:0]           mult_in1,
  input  logic [15:0]          mult_out
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } op_t;

  state_t             state, state_d;
  op_t  [NUM_REQ-1:0] ops;
  logic [IDX_W-1:0]   ptr, owner, winner, cand;
  logic [CNT_W-1:0]   cnt;
  logic               found, grant_en;

  // Unpack the flat operand buses into one struct per lane.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ops
    assign ops[i].a = req_a[8*i +: 8];
    assign ops[i].b = req_b[8*i +: 8];
  end

  // Round-robin pick: first set req bit scanning upward from ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // A grant is only offered from IDLE, and never while reset is held.
  assign grant_en = (state == IDLE) && found && !rst;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    mult_share_lane #(.LANE(i), .IDX_W(IDX_W)) u_lane (
      .grant_en  (grant_en),
      .winner    (winner),
      .done      (state == DONE),
      .owner     (owner),
      .gnt       (gnt[i]),
      .res_valid (res_valid[i])
    );
  end

  // Next-state logic and the strobes that depend only on the state.
  always_comb begin
    state_d    = state;
    mult_start = 1'b0;
    busy       = grant_en;
    case (state)
      IDLE:  if (grant_en) state_d = START;
      START: begin
        mult_start = 1'b1;
        busy       = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (cnt == '0) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Datapath: operand latch at grant, latency countdown, result capture, pointer advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner    <= '0;
      ptr      <= '0;
      cnt      <= '0;
      mult_in0 <= '0;
      mult_in1 <= '0;
      res_data <= '0;
    end else begin
      case (state)
        IDLE: if (grant_en) begin
          owner    <= winner;
          mult_in0 <= ops[winner].a;
          mult_in1 <= ops[winner].b;
        end
        START: cnt <= CNT_W'(MULT_LATENCY - 1);
        WAIT: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           res_data <= mult_out;
        end
        DONE: ptr <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a fixed-latency multiplier model
// and a cycle-by-cycle reference model of the grant/result timeline.
module tb_mult_share_arbiter;
  localparam int N = 4;
  localparam int L = 9;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_a = '0, req_b = '0;
  logic [N-1:0]   gnt, res_valid;
  logic [15:0]    res_data;
  logic           busy, mult_start;
  logic [7:0]     mult_in0, mult_in1;
  logic [15:0]    mult_out = 16'hDEAD;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_share_arbiter #(.NUM_REQ(N), .MULT_LATENCY(L), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .res_valid(res_valid), .res_data(res_data), .busy(busy),
    .mult_start(mult_start), .mult_in0(mult_in0), .mult_in1(mult_in1),
    .mult_out(mult_out)
  );

  // Sequential multiplier: product appears MULT_LATENCY cycles after the start cycle,
  // garbage before that.
  int          m_cnt  = 0;
  logic [15:0] m_prod = '0;
  always @(posedge clk) begin
    if (mult_start) begin
      m_cnt    <= L - 1;
      m_prod   <= {8'h00, mult_in0} * {8'h00, mult_in1};
      mult_out <= 16'hDEAD;
    end else if (m_cnt > 1) begin
      m_cnt    <= m_cnt - 1;
      mult_out <= 16'hDEAD;
    end else if (m_cnt == 1) begin
      m_cnt    <= 0;
      mult_out <= m_prod;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  // Reference model: timeline relative to the grant cycle.
  int          cyc = 0, m_t0 = 0, m_own = 0, m_ptr = 0;
  bit          started = 0, m_act = 0;
  logic [7:0]  m_a = '0, m_b = '0;
  logic [15:0] m_rd = '0;

  always @(negedge clk) begin
    logic [N-1:0] e_gnt, e_rv;
    logic         e_ms, e_busy;
    int           w, d;
    cyc++;
    if (rst) begin
      started = 1; m_act = 0; m_ptr = 0; m_rd = '0; m_a = '0; m_b = '0;
    end else if (started) begin
      e_gnt = '0; e_rv = '0; e_ms = 0; e_busy = 0; w = -1; d = cyc - m_t0;
      if (!m_act) begin
        w = rr_pick(req, m_ptr);
        if (w >= 0) begin e_gnt[w] = 1'b1; e_busy = 1; end
      end else begin
        e_busy = 1;
        e_ms   = (d == 1);
        if (d == L + 2) begin
          e_rv[m_own] = 1'b1;
          m_rd = {8'h00, m_a} * {8'h00, m_b};
        end
      end
      chk("cmp_gnt",        32'(gnt),        32'(e_gnt));
      chk("cmp_res_valid",  32'(res_valid),  32'(e_rv));
      chk("cmp_mult_start", 32'(mult_start), 32'(e_ms));
      chk("cmp_busy",       32'(busy),       32'(e_busy));
      chk("cmp_res_data",   32'(res_data),   32'(m_rd));
      chk("cmp_mult_in0",   32'(mult_in0),   32'(m_a));
      chk("cmp_mult_in1",   32'(mult_in1),   32'(m_b));
      if (!m_act && w >= 0) begin
        m_act = 1; m_t0 = cyc; m_own = w;
        m_a = req_a[8*w +: 8]; m_b = req_b[8*w +: 8];
      end else if (m_act && d == L + 2) begin
        m_act = 0; m_ptr = (m_own + 1) % N;
      end
    end
  end

  task automatic drive(input logic [N-1:0] r);
    @(posedge clk); #1;
    req = r;
  endtask

  task automatic set_op(input int lane, input logic [7:0] a, input logic [7:0] b);
    req_a[8*lane +: 8] = a;
    req_b[8*lane +: 8] = b;
  endtask

  task automatic wait_gnt(input int lim, output int lane, output int n);
    lane = -1; n = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk); n++;
      if (gnt != '0) begin lane = oh_idx(gnt); break; end
    end
    if (lane < 0) chk("gnt_timeout", 32'(n), 32'(lim + 1));
  endtask

  task automatic wait_rv(input int lim, output int lane, output int n, output int bc);
    lane = -1; n = 0; bc = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk); n++;
      if (busy) bc++;
      if (res_valid != '0) begin lane = oh_idx(res_valid); break; end
    end
    if (lane < 0) chk("rv_timeout", 32'(n), 32'(lim + 1));
  endtask

  initial begin
    int lane, n, bc;
    // Reset state
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_gnt",        32'(gnt),        0);
    chk("rst_res_valid",  32'(res_valid),  0);
    chk("rst_mult_start", 32'(mult_start), 0);
    chk("rst_busy",       32'(busy),       0);
    chk("rst_res_data",   32'(res_data),   0);
    chk("rst_mult_in0",   32'(mult_in0),   0);

    // Single request
    @(posedge clk); #1;
    rst = 1'b0; req = 4'b0001; set_op(0, 8'h06, 8'hFB);
    wait_gnt(10, lane, n);
    chk("single_gnt_lane", lane, 0);
    chk("single_gnt_delay", n, 1);
    drive('0);
    wait_rv(30, lane, n, bc);
    chk("single_rv_delay", n, 11);
    chk("single_rv_lane", lane, 0);
    chk("single_data", 32'(res_data), 32'h05E2);
    chk("single_busy_len", bc + 1, 12);
    @(negedge clk);
    chk("single_idle_busy", 32'(busy), 0);

    // All four requesting, fresh pointer
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, 8'(i + 1), 8'h10);
    req = 4'b1111;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      wait_gnt(40, lane, n);
      chk("all_gnt_lane", lane, k);
      if (k > 0) chk("all_gnt_gap", n, 1);
      if (k == N - 1) drive('0);
      wait_rv(30, lane, n, bc);
      chk("all_rv_delay", n, 11);
      chk("all_rv_lane", lane, k);
      chk("all_data", 32'(res_data), 32'((k + 1) * 16));
    end

    // Round-robin pointer after lane 2
    drive(4'b0100); set_op(2, 8'h07, 8'h09);
    wait_gnt(10, lane, n);
    chk("rr_gnt2", lane, 2);
    drive('0);
    wait_rv(30, lane, n, bc);
    chk("rr_data2", 32'(res_data), 32'h003F);
    drive(4'b1001); set_op(3, 8'hFF, 8'hFF); set_op(0, 8'h80, 8'h02);
    wait_gnt(10, lane, n);
    chk("rr_first_lane3", lane, 3);
    drive(4'b0001);
    wait_rv(30, lane, n, bc);
    chk("rr_rv_lane3", lane, 3);
    chk("rr_data3", 32'(res_data), 32'hFE01);
    wait_gnt(10, lane, n);
    chk("rr_then_lane0", lane, 0);
    chk("rr_then_gap", n, 1);
    drive('0);
    wait_rv(30, lane, n, bc);
    chk("rr_data0", 32'(res_data), 32'h0100);

    // Operand stability while the multiplier runs
    drive(4'b0010); set_op(1, 8'h12, 8'h34);
    wait_gnt(10, lane, n);
    chk("stab_gnt", lane, 1);
    lane = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      req = '0; set_op(1, 8'($urandom), 8'($urandom));
      @(negedge clk);
      chk("stab_in0", 32'(mult_in0), 32'h12);
      chk("stab_in1", 32'(mult_in1), 32'h34);
      if (res_valid != '0) begin lane = oh_idx(res_valid); break; end
    end
    chk("stab_rv_lane", lane, 1);
    chk("stab_data", 32'(res_data), 32'h03A8);

    // Reset during WAIT
    drive(4'b0100); set_op(2, 8'h03, 8'h05);
    wait_gnt(10, lane, n);
    chk("abort_gnt", lane, 2);
    drive('0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_gnt0",  32'(gnt),        0);
    chk("abort_rv0",   32'(res_valid),  0);
    chk("abort_ms0",   32'(mult_start), 0);
    chk("abort_busy0", 32'(busy),       0);
    chk("abort_data0", 32'(res_data),   0);
    chk("abort_in0",   32'(mult_in0),   0);
    chk("abort_in1",   32'(mult_in1),   0);
    for (int i = 0; i < N; i++) set_op(i, 8'(i + 1), 8'h10);
    drive(4'b1111);
    wait_gnt(10, lane, n);
    chk("abort_regrant_lane0", lane, 0);
    drive('0);
    wait_rv(30, lane, n, bc);
    chk("abort_rv_lane", lane, 0);
    chk("abort_data", 32'(res_data), 32'h0010);

    // Withdrawal while another lane is busy
    drive(4'b0001); set_op(0, 8'h02, 8'h03);
    wait_gnt(10, lane, n);
    chk("wd_gnt", lane, 0);
    drive(4'b0010);
    repeat (4) @(posedge clk);
    #1 req = '0;
    wait_rv(30, lane, n, bc);
    chk("wd_rv_lane", lane, 0);
    chk("wd_data", 32'(res_data), 32'h0006);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wd_no_gnt", 32'(gnt), 0);
      chk("wd_idle", 32'(busy), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
